instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of instruction_memory (128 x 32, combinational read).

---
 rtl/instruction_fetch.sv | 82 ++++++++
 tb/tb_instruction_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_we,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_valid,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;

  assign imem_addr = pc;
  assign imem_we   = 1'b0;

  // Priority on every edge: reset > branch_taken > stall > fetch.
  // halted mirrors the HALTED state and is the externally visible FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc          <= branch_target;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_id_instr <= imem_data;
          if_id_pc    <= pc;
          if_id_valid <= 1'b1;
          if (!(&fetch_count)) begin
            fetch_count <= fetch_count + 1'b1;
          end
          // A halt word is delivered to decode, but the PC stops on it.
          if (imem_data == HALT_WORD) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        HALTED: begin
          if_id_instr <= '0;
          if_id_valid <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed scenarios followed by
// randomized stall/branch/reset traffic against a behavioural model.
module tb_instruction_fetch;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int CNT_W = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] HALT = 32'hFFFF_FFFF;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [AW-1:0]     branch_target = '0;
  logic [DW-1:0]     imem_data;
  logic [AW-1:0]     imem_addr;
  logic              imem_we;
  logic [DW-1:0]     if_id_instr;
  logic [AW-1:0]     if_id_pc;
  logic              if_id_valid;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  logic [DW-1:0] mem [DEPTH];
  assign imem_data = mem[imem_addr];

  instruction_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC('0),
    .HALT_WORD(HALT),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_data(imem_data),
    .imem_addr(imem_addr),
    .imem_we(imem_we),
    .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  // scoreboard
  typedef struct packed {
    logic [AW-1:0]    pc;
    logic [DW-1:0]    instr;
    logic [AW-1:0]    ipc;
    logic             valid;
    logic             halted;
    logic [CNT_W-1:0] count;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: architectural view of the fetch stage
  int          m_pc = 0;
  logic [DW-1:0] m_instr = '0;
  int          m_ipc = 0;
  bit          m_valid = 0;
  bit          m_halted = 0;
  int          m_count = 0;

  function automatic void model_edge(input bit rst, input bit stl, input bit br, input int tgt);
    logic [DW-1:0] w;
    if (rst) begin
      m_pc = 0; m_instr = '0; m_ipc = 0; m_valid = 0; m_halted = 0; m_count = 0;
    end else if (br) begin
      m_pc = tgt; m_instr = '0; m_valid = 0; m_halted = 0;
    end else if (stl) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = '0; m_valid = 0;
    end else begin
      w = mem[m_pc];
      m_instr = w;
      m_ipc = m_pc;
      m_valid = 1;
      m_count = (m_count >= CNT_MAX) ? CNT_MAX : m_count + 1;
      if (w == HALT) m_halted = 1;
      else m_pc = (m_pc + 1) % DEPTH;
    end
  endfunction

  // driver
  task automatic step(input bit rst, input bit stl, input bit br, input int tgt);
    exp_t e;
    reset = rst;
    stall = stl;
    branch_taken = br;
    branch_target = AW'(tgt);
    model_edge(rst, stl, br, tgt);
    e.pc = AW'(m_pc);
    e.instr = m_instr;
    e.ipc = AW'(m_ipc);
    e.valid = m_valid;
    e.halted = m_halted;
    e.count = CNT_W'(m_count);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // monitor: one expected entry per clock edge, sampled 1 time unit after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", 32'(imem_addr), 32'(e.pc));
        chk("imem_we", 32'(imem_we), 32'd0);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk("if_id_instr", if_id_instr, e.instr);
        if (e.valid) chk("if_id_pc", 32'(if_id_pc), 32'(e.ipc));
        chk("halted", 32'(halted), 32'(e.halted));
        chk("fetch_count", 32'(fetch_count), 32'(e.count));
      end
    end
  end

  initial begin
    int wait_cycles;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(DEPTH - i);

    // sequential fetch with PC wrap
    step(1, 0, 0, 0);
    run(130);

    // stall hold at pc=5
    step(1, 0, 0, 0);
    run(5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    run(3);

    // taken branch at pc=10
    run(2);
    step(0, 0, 1, 'h40);
    run(2);

    // halt word at address 20, then branch back to 0
    mem[20] = HALT;
    step(1, 0, 0, 0);
    run(21);
    run(3);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    run(3);
    mem[20] = DW'(DEPTH - 20);

    // branch beats stall, then resets mid-stall and mid-halt
    step(1, 0, 0, 0);
    run(7);
    step(0, 1, 1, 3);
    run(2);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    run(2);
    mem[6] = HALT;
    run(8);
    step(1, 0, 0, 0);
    run(2);
    mem[6] = DW'(DEPTH - 6);

    // fetch_count saturation
    step(1, 0, 0, 0);
    run(CNT_MAX + 10);

    // randomized traffic
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, DEPTH - 1));
    end
    step(0, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
